// File: rtl/button_event_gen_pkg.sv
// Shared types and level constants for the button event generator.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHORT,
    S_LONG
  } btn_state_t;

  localparam logic BTN_PRESSED  = 1'b0;
  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_event_gen_edge_detect.sv
// Registered-history edge detector for a level already synchronous to clk.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic din_q;

  // The reset value defines what the first post-reset sample is compared against.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= RESET_VAL;
    end else begin
      din_q <= din;
    end
  end

  assign fall = din_q & ~din;
  assign rise = ~din_q & din;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced active-low button level into press/release/click/long strobes.
// Define BTN_EVT_REPEAT_EN to add auto-repeat strobes while in long hold.
module button_event_gen
  import btn_evt_pkg::*;
#(
  parameter int               CNT_W         = 26,
  parameter logic [CNT_W-1:0] LONG_CYCLES   = 26'd50_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CYCLES = 26'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic long_held
);

  btn_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             fall;
  logic             rise;

  edge_detect #(
    .RESET_VAL(BTN_RELEASED)
  ) u_edge (
    .clk (clk),
    .rst (rst),
    .din (btn_n),
    .fall(fall),
    .rise(rise)
  );

`ifdef BTN_EVT_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
      long_held     <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rpt_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (fall) begin
            press_pulse <= 1'b1;
            held        <= 1'b1;
            hold_cnt    <= '0;
            state       <= S_SHORT;
          end
        end
        S_SHORT: begin
          hold_cnt <= hold_cnt + 1'b1;
          // A release landing on the threshold cycle still counts as a click.
          if (rise) begin
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            held          <= 1'b0;
            state         <= S_IDLE;
          end else if (hold_cnt == LONG_CYCLES - 1'b1) begin
            long_pulse <= 1'b1;
            long_held  <= 1'b1;
`ifdef BTN_EVT_REPEAT_EN
            rpt_cnt    <= '0;
`endif
            state      <= S_LONG;
          end
        end
        S_LONG: begin
          if (rise) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            long_held     <= 1'b0;
            state         <= S_IDLE;
          end
`ifdef BTN_EVT_REPEAT_EN
          else if (rpt_cnt == REPEAT_CYCLES - 1'b1) begin
            repeat_pulse <= 1'b1;
            rpt_cnt      <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
